imem_loader: RTL and testbench

- Writer-side counterpart to the read-only instruction memory.
- Accepts a byte stream from a host link over a valid/ready handshake and parses a framed program image: word count, big-endian 32-bit instruction words, then a checksum.
- Emits one-cycle word writes into the instruction memory's write port, at byte addresses aligned to 4.
- Sits between the host link (UART receiver or testbench) and the instruction memory. The CPU is held in reset while the loader is busy.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the
// instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 4;
  localparam int CSUM_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// imem_loader_byte_assembler: packs a big-endian byte stream into 32-bit words.
//   clk, rst_n  : clock, async active-low reset
//   clr         : sync clear of byte index and shift register
//   take        : a byte is consumed this cycle
//   byte_in     : stream byte
//   word_valid  : high in the cycle the 4th byte of a group is consumed
//   word        : assembled word, valid while word_valid is high
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q;
  // Only the three earlier bytes need to be kept; the 4th comes straight
  // from byte_in so the owner can register the word on the same edge.
  logic [23:0] sreg_q;

  assign word_valid = take && (idx_q == 2'(WORD_BYTES - 1));
  assign word       = {sreg_q, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      sreg_q <= '0;
    end else if (clr) begin
      idx_q  <= '0;
      sreg_q <= '0;
    end else if (take) begin
      idx_q  <= idx_q + 2'd1;
      sreg_q <= {sreg_q[15:0], byte_in};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a framed program image (word count, big-endian data
// words, checksum) from a byte stream and writes it into instruction memory.
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a load (IDLE only)
//   abort               : drop the load and flag error (ignored in IDLE)
//   byte_in/byte_valid  : stream input; byte_ready is high while busy
//   wr_en/wr_addr/wr_data : one-cycle word write strobe, registered addr/data
//   busy, done, error   : status; done/error sticky until next start
//   word_count          : words written in current/last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 512,
  parameter int          CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 wr_en,
  output logic [31:0]          wr_addr,
  output logic [31:0]          wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] word_count
);

  state_t               state_q, state_d;
  logic                 take, clr, wv, last, oversize;
  logic [31:0]          word, acc_q;
  logic [CNT_WIDTH-1:0] n_words_q;

  assign busy       = (state_q != IDLE);
  assign byte_ready = busy;
  // Abort wins over a concurrent byte: the byte is not consumed.
  assign take       = byte_valid && busy && !abort;
  assign clr        = ((state_q == IDLE) && start) || (busy && abort);
  assign last       = ((word_count + CNT_WIDTH'(1)) == n_words_q);
  assign oversize   = (word > 32'(MAX_WORDS));

  imem_loader_byte_assembler u_byte_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .take       (take),
    .byte_in    (byte_in),
    .word_valid (wv),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        if (abort)   state_d = IDLE;
        else if (wv) state_d = oversize ? IDLE : (word == 32'd0) ? CSUM : DATA;
      end
      DATA: begin
        if (abort)           state_d = IDLE;
        else if (wv && last) state_d = CSUM;
      end
      CSUM: begin
        if (abort || wv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      acc_q      <= '0;
      n_words_q  <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          done       <= 1'b0;
          error      <= 1'b0;
          word_count <= '0;
          acc_q      <= '0;
        end
        HDR: begin
          if (abort) error <= 1'b1;
          else if (wv) begin
            n_words_q <= word[CNT_WIDTH-1:0];
            if (oversize) error <= 1'b1;
          end
        end
        DATA: begin
          if (abort) error <= 1'b1;
          else if (wv) begin
            wr_en      <= 1'b1;
            wr_addr    <= BASE_ADDR + {{(30-CNT_WIDTH){1'b0}}, word_count, 2'b00};
            wr_data    <= word;
            acc_q      <= acc_q + word;
            word_count <= word_count + CNT_WIDTH'(1);
          end
        end
        CSUM: begin
          if (abort) error <= 1'b1;
          else if (wv) begin
            if (word == acc_q) done  <= 1'b1;
            else               error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, busy, done, error;
  logic [31:0] wr_addr, wr_data;
  logic [9:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en) begin
    wa.push_back(wr_addr);
    wd.push_back(wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = byte_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++)
      send(w[31-8*k -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load(input logic [31:0] n, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] cs, input int maxgap);
    wa.delete(); wd.delete();
    pulse_start();
    send_word(n, maxgap);
    if (n > 0) send_word(w0, maxgap);
    if (n > 1) send_word(w1, maxgap);
    send_word(cs, maxgap);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_wren", {31'b0, wr_en}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, error}, 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_wc", {22'b0, word_count}, 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // nominal
    load(32'd2, 32'h2408_0005, 32'h0000_0008, 32'h2408_000D, 0);
    chk("nom_done", {31'b0, done}, 32'd1);
    chk("nom_err", {31'b0, error}, 32'd0);
    chk("nom_busy", {31'b0, busy}, 32'd0);
    chk("nom_wc", {22'b0, word_count}, 32'd2);
    chk("nom_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("nom_a0", wa[0], 32'h0);
      chk("nom_d0", wd[0], 32'h2408_0005);
      chk("nom_a1", wa[1], 32'h4);
      chk("nom_d1", wd[1], 32'h0000_0008);
    end

    // bad checksum
    load(32'd2, 32'h2408_0005, 32'h0000_0008, 32'h2408_000E, 0);
    chk("bad_done", {31'b0, done}, 32'd0);
    chk("bad_err", {31'b0, error}, 32'd1);
    chk("bad_nwr", wa.size(), 32'd2);
    chk("bad_wc", {22'b0, word_count}, 32'd2);

    // oversize header: error right after the 4th header byte
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'h0000_0201, 0);
    chk("ovr_err", {31'b0, error}, 32'd1);
    chk("ovr_busy", {31'b0, busy}, 32'd0);
    chk("ovr_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("ovr_nwr", wa.size(), 32'd0);

    // backpressure gaps; start must also clear the previous error
    load(32'd2, 32'h2408_0005, 32'h0000_0008, 32'h2408_000D, 3);
    chk("gap_done", {31'b0, done}, 32'd1);
    chk("gap_err", {31'b0, error}, 32'd0);
    chk("gap_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("gap_a0", wa[0], 32'h0);
      chk("gap_d0", wd[0], 32'h2408_0005);
      chk("gap_a1", wa[1], 32'h4);
      chk("gap_d1", wd[1], 32'h0000_0008);
    end

    // empty image
    load(32'd0, 32'h0, 32'h0, 32'h0, 0);
    chk("emp_done", {31'b0, done}, 32'd1);
    chk("emp_err", {31'b0, error}, 32'd0);
    chk("emp_nwr", wa.size(), 32'd0);
    chk("emp_wc", {22'b0, word_count}, 32'd0);

    // abort after 2 bytes of word 1
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h2408_0005, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'h00;
    @(posedge clk); #1;
    abort = 1'b0; byte_valid = 1'b0;
    chk("abt_err", {31'b0, error}, 32'd1);
    chk("abt_done", {31'b0, done}, 32'd0);
    chk("abt_busy", {31'b0, busy}, 32'd0);
    chk("abt_wc", {22'b0, word_count}, 32'd1);
    chk("abt_nwr", wa.size(), 32'd1);

    // reset mid-word: outputs clear without a clock edge
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h2408_0005, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    byte_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_ready", {31'b0, byte_ready}, 32'd0);
    chk("mrst_wren", {31'b0, wr_en}, 32'd0);
    chk("mrst_data", wr_data, 32'd0);
    chk("mrst_wc", {22'b0, word_count}, 32'd0);
    chk("mrst_err", {31'b0, error}, 32'd0);
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    byte_valid = 1'b1;
    repeat (4) @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("mrst_nwr", wa.size(), 32'd1);
    chk("mrst_idle", {31'b0, busy}, 32'd0);

    // start pulsed during DATA is ignored
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h2408_0005, 0);
    start = 1'b1;
    send(8'h00, 0);
    start = 1'b0;
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h08, 0);
    send_word(32'h2408_000D, 0);
    chk("sb_done", {31'b0, done}, 32'd1);
    chk("sb_err", {31'b0, error}, 32'd0);
    chk("sb_wc", {22'b0, word_count}, 32'd2);
    chk("sb_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) chk("sb_d1", wd[1], 32'h0000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
